seven_seg_scan_ctrl: RTL and testbench

- Time-shares one Display_Seven hex decoder (In[3:0] -> Out[6:0], DE2 active-low segments) across N_DIGITS HEX displays.
- Accepts a full display word over a valid/ready handshake, then steps each nibble through the shared decoder.
- Captures each decoded pattern into a per-digit segment register that drives the static DE2 HEX pins.
- Sits between the application logic (counters, ALU results) and the board display pins.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_scan_ctrl_if.sv | 29 ++
 rtl/seven_seg_lz_mask.sv | 34 +++
 rtl/seven_seg_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared widths, segment constants and scan state type for the HEX scan controller
package seven_seg_pkg;

    localparam int SEG_W = 7;
    localparam int NIB_W = 4;

    // DE2 segments are active-low: all ones is dark, 7'h40 lights every segment but g.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'h40;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CAPTURE,
        S_DONE
    } scan_state_e;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - display word write handshake (wr_valid/wr_ready/wr_data/wr_blank)
//
// master: producer of display words; slave: seven_seg_scan_ctrl.
//   wr_valid  producer offers a word
//   wr_ready  controller idle, word taken on the edge where both are high
//   wr_data   nibble i = wr_data[4*i+3:4*i], digit 0 rightmost
//   wr_blank  bit i forces digit i dark
interface seven_seg_scan_ctrl_if #(
    parameter int N_DIGITS = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [4*N_DIGITS-1:0] wr_data;
    logic [N_DIGITS-1:0]   wr_blank;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_blank,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_blank,
        output wr_ready
    );
endinterface

// File: rtl/seven_seg_lz_mask.sv
// rtl/seven_seg_lz_mask.sv - combinational leading-zero blank mask generator
//
// Ports:
//   nibbles    4*N_DIGITS  display word, digit 0 rightmost
//   blank_in   N_DIGITS    caller-requested blank mask
//   blank_out  N_DIGITS    blank_in plus leading zeros; digit 0 is never leading-blanked
// Only instantiated when SEVEN_SEG_LEADING_ZERO_BLANK_EN is defined.
module seven_seg_lz_mask
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS = 8
) (
    input  logic [NIB_W*N_DIGITS-1:0] nibbles,
    input  logic [N_DIGITS-1:0]       blank_in,
    output logic [N_DIGITS-1:0]       blank_out
);

    // Walk from the most significant digit down; higher_dark stays set while
    // every digit above the current one is either zero or explicitly blanked.
    logic higher_dark;

    always_comb begin
        blank_out   = blank_in;
        higher_dark = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if ((nibbles[i*NIB_W +: NIB_W] == '0) && higher_dark) begin
                blank_out[i] = 1'b1;
            end
            higher_dark = higher_dark &&
                          ((nibbles[i*NIB_W +: NIB_W] == '0) || blank_in[i]);
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-shares one external hex decoder across N_DIGITS HEX displays
//
// Ports:
//   clk, rst   single clock, synchronous active-high reset
//   wr         seven_seg_scan_ctrl_if.slave display word handshake
//   dec_in     nibble presented to the shared Display_Seven decoder
//   dec_out    active-low pattern returned combinationally by the decoder
//   seg_out    per-digit segment registers, digit i = seg_out[7*i+6:7*i]
//   busy       scan in progress
//   done       one-cycle pulse after the last digit is captured
// Optional: SEVEN_SEG_LEADING_ZERO_BLANK_EN adds leading-zero blanking at accept.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int DIG_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    seven_seg_scan_ctrl_if.slave      wr,
    output logic [NIB_W-1:0]          dec_in,
    input  logic [SEG_W-1:0]          dec_out,
    output logic [SEG_W*N_DIGITS-1:0] seg_out,
    output logic                      busy,
    output logic                      done
);

    scan_state_e               state_q, state_d;
    logic [DIG_W-1:0]          idx_q, idx_d;
    logic [NIB_W*N_DIGITS-1:0] data_q, data_d;
    logic [N_DIGITS-1:0]       blank_q, blank_d;
    logic [NIB_W-1:0]          dec_in_q, dec_in_d;
    logic [SEG_W*N_DIGITS-1:0] seg_q, seg_d;
    logic [N_DIGITS-1:0]       eff_blank;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    seven_seg_lz_mask #(
        .N_DIGITS (N_DIGITS)
    ) u_lz_mask (
        .nibbles   (wr.wr_data),
        .blank_in  (wr.wr_blank),
        .blank_out (eff_blank)
    );
`else
    assign eff_blank = wr.wr_blank;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            data_q   <= '0;
            blank_q  <= '0;
            dec_in_q <= '0;
            seg_q    <= {N_DIGITS{SEG_BLANK}};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            blank_q  <= blank_d;
            dec_in_q <= dec_in_d;
            seg_q    <= seg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        blank_d  = blank_q;
        dec_in_d = dec_in_q;
        seg_d    = seg_q;

        unique case (state_q)
            S_IDLE: begin
                if (wr.wr_valid) begin
                    data_d  = wr.wr_data;
                    blank_d = eff_blank;
                    idx_d   = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (idx_q == DIG_W'(i)) begin
                        dec_in_d = data_q[i*NIB_W +: NIB_W];
                    end
                end
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // dec_in_q has been stable for a full cycle, so dec_out is settled.
                // Blanked digits still take this slot to keep timing data-independent.
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (idx_q == DIG_W'(i)) begin
                        seg_d[i*SEG_W +: SEG_W] = blank_q[i] ? SEG_BLANK : dec_out;
                    end
                end
                if (idx_q == DIG_W'(N_DIGITS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + DIG_W'(1);
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wr.wr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign dec_in      = dec_in_q;
    assign seg_out     = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl with a Display_Seven model
module tb_seven_seg_scan_ctrl;

    localparam int N = 8;

    logic          clk;
    logic          rst;
    logic [3:0]    dec_in;
    logic [6:0]    dec_out;
    logic [7*N-1:0] seg_out;
    logic          busy;
    logic          done;

    seven_seg_scan_ctrl_if #(.N_DIGITS(N)) wr_if ();

    seven_seg_scan_ctrl #(
        .N_DIGITS (N),
        .DIG_W    (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr_if.slave),
        .dec_in  (dec_in),
        .dec_out (dec_out),
        .seg_out (seg_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;

    // DE2 Display_Seven, active-low segments gfedcba
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    assign dec_out = seg7(dec_in);

    function automatic logic [7:0] eff_blank(input logic [31:0] d, input logic [7:0] b);
        logic [7:0] e;
        e = b;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < N; i++) begin
            bit all_dark;
            all_dark = 1'b1;
            for (int j = i + 1; j < N; j++)
                if (d[4*j +: 4] != 4'h0 && !b[j]) all_dark = 1'b0;
            if (d[4*i +: 4] == 4'h0 && all_dark) e[i] = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: cycles counted from the accept edge.
    // k even = nibble k/2 being driven, k odd = digit (k-1)/2 captured at end of cycle,
    // k == 2N = done cycle.
    bit          m_on = 1'b0;
    bit          m_active;
    int          m_k;
    logic [31:0] m_data;
    logic [7:0]  m_blank;
    logic [3:0]  m_dec;
    logic [6:0]  m_seg [N];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_on     = 1'b1;
            m_active = 1'b0;
            m_k      = 0;
            m_dec    = 4'h0;
            for (int i = 0; i < N; i++) m_seg[i] = 7'h7F;
        end else if (m_on) begin
            if (!m_active) begin
                if (wr_if.wr_valid) begin
                    m_data   = wr_if.wr_data;
                    m_blank  = eff_blank(wr_if.wr_data, wr_if.wr_blank);
                    m_active = 1'b1;
                    m_k      = 0;
                end
            end else if (m_k == 2 * N) begin
                m_active = 1'b0;
            end else begin
                if (m_k % 2 == 0) begin
                    m_dec = m_data[4*(m_k/2) +: 4];
                end else begin
                    int d;
                    d = (m_k - 1) / 2;
                    m_seg[d] = m_blank[d] ? 7'h7F : seg7(m_data[4*d +: 4]);
                end
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            logic [7*N-1:0] exp_seg;
            for (int i = 0; i < N; i++) exp_seg[7*i +: 7] = m_seg[i];
            check("wr_ready", 64'(wr_if.wr_ready), 64'(!m_active));
            check("busy",     64'(busy),           64'(m_active));
            check("done",     64'(done),           64'(m_active && m_k == 2 * N));
            check("dec_in",   64'(dec_in),         64'(m_dec));
            check("seg_out",  64'(seg_out),        64'(exp_seg));
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] b, output int t);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
        wr_if.wr_blank = b;
        t = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (wr_if.wr_ready === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("accept_timeout", 64'd0, 64'd1);
        step(1);
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = $urandom;
        wr_if.wr_blank = 8'($urandom);
    endtask

    task automatic wait_done(input string name, input int t0, input int exp_delta);
        int seen;
        seen = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = cyc - t0;
                break;
            end
        end
        check(name, 64'(seen), 64'(exp_delta));
        step(1);
    endtask

    initial begin
        int t, t2, dc;
        logic [31:0] d;
        logic [7:0]  b;

        rst            = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 32'hDEADBEEF;
        wr_if.wr_blank = 8'h00;
        step(2);
        check("rst_seg",   64'(seg_out), 64'({N{7'h7F}}));
        check("rst_ready", 64'(wr_if.wr_ready), 64'd1);
        check("rst_busy",  64'(busy), 64'd0);
        rst            = 1'b0;
        wr_if.wr_valid = 1'b0;
        step(2);
        check("rst_no_accept", 64'(busy), 64'd0);

        // full word
        send(32'h76543210, 8'h00, t);
        wait_done("full_done_lat", t, 17);
        check("full_dig0", 64'(seg_out[6:0]),   64'h40);
        check("full_dig1", 64'(seg_out[13:7]),  64'h79);
        check("full_dig7", 64'(seg_out[55:49]), 64'h78);

        // blank mask
        send(32'hFFFFFFFF, 8'hF0, t);
        wait_done("blank_done_lat", t, 17);
        check("blank_lo", 64'(seg_out[27:0]),  64'({4{7'h0E}}));
        check("blank_hi", 64'(seg_out[55:28]), 64'({4{7'h7F}}));

        // busy backpressure
        send(32'h89ABCDEF, 8'h00, t);
        step(2);
        send(32'h11111111, 8'h00, t2);
        check("bp_accept", 64'(t2 - t), 64'd18);
        wait_done("bp_done2_lat", t, 35);
        check("bp_word2", 64'(seg_out), 64'({N{7'h79}}));

        // reset mid-scan
        send(32'h22222222, 8'h00, t);
        step(5);
        rst = 1'b1;
        dc  = done_cnt;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_seg",   64'(seg_out), 64'({N{7'h7F}}));
        check("mid_rst_ready", 64'(wr_if.wr_ready), 64'd1);
        step(20);
        check("mid_rst_no_done", 64'(done_cnt), 64'(dc));

        // leading zeros
        send(32'h00000A00, 8'h00, t);
        wait_done("lz_done_lat", t, 17);
        check("lz_dig2",  64'(seg_out[20:14]), 64'h08);
        check("lz_dig10", 64'(seg_out[13:0]),  64'({2{7'h40}}));
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        check("lz_hi", 64'(seg_out[55:21]), 64'({5{7'h7F}}));
`else
        check("lz_hi", 64'(seg_out[55:21]), 64'({5{7'h40}}));
`endif

        // back-to-back
        send(32'h13572468, 8'h00, t);
        send(32'h02468ACE, 8'h00, t2);
        check("b2b_spacing", 64'(t2 - t), 64'd18);
        wait_done("b2b_done_lat", t2, 17);

        // randomized words
        for (int r = 0; r < 25; r++) begin
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d = d >> (4 * $urandom_range(1, 7));
            b = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            send(d, b, t);
            if ($urandom_range(0, 1) == 0) begin
                wait_done("rnd_done_lat", t, 17);
                step($urandom_range(0, 3));
            end
        end
        step(2 * N + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
